// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
// Holds the RV32I funct3 size/sign codes, the FSM state type and small
// decode helpers used by load_store_unit and lsu_load_align.
package lsu_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Access size codes
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // FSM state type and encodings
    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE   = 2'd0;
    localparam lsu_state_t ST_REQ    = 2'd1;
    localparam lsu_state_t ST_WAIT_R = 2'd2;
    localparam lsu_state_t ST_DONE   = 2'd3;

    // Access size; the undefined codes (011, 110, 111) fall through to word.
    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        logic [1:0] sz;
        case (f3)
            F3_LB, F3_LBU: sz = SZ_BYTE;
            F3_LH, F3_LHU: sz = SZ_HALF;
            F3_LW:         sz = SZ_WORD;
            default:       sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Natural-alignment check for the given size and low address bits.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic m;
        case (f3_size(f3))
            SZ_HALF: m = lo[0];
            SZ_WORD: m = (lo != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/half out of a bus read word and
// sign- or zero-extends it; full words pass through unchanged.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic        [7:0]  byte_sel;
    logic        [15:0] half_sel;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] byte_sx;
    logic signed [31:0] half_sx;

    // Lane select, extension and size mux
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        byte_s   = signed'(byte_sel);
        half_s   = signed'(half_sel);
        byte_sx  = 32'(byte_s);
        half_sx  = 32'(half_s);
        case (f3_size(funct3))
            SZ_BYTE: result = funct3[2] ? {24'd0, byte_sel} : unsigned'(byte_sx);
            SZ_HALF: result = funct3[2] ? {16'd0, half_sel} : unsigned'(half_sx);
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store engine between the
// core and a valid/ready memory bus with a separate read-data valid.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses are
// reported through fault with no bus access; without it fault is tied low
// and the misaligned low address bits are ignored.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        done,
    output logic [31:0] ReadData,
    output logic        fault,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);

    lsu_state_t  state;
    lsu_state_t  state_nxt;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic        accept;
    logic        req_misaligned;
    logic        load_capture;
    logic [3:0]  st_strb;
    logic [31:0] st_lanes;
    logic [31:0] load_result;

    assign accept    = (state == ST_IDLE) && req_valid;
    assign req_ready = (state == ST_IDLE);
    assign mem_valid = (state == ST_REQ);
    assign done      = (state == ST_DONE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misaligned = misaligned(req_funct3, req_addr[1:0]);
`else
    assign req_misaligned = 1'b0;
`endif

    // A load result is taken either together with the request handshake or later in WAIT_R
    assign load_capture = mem_rvalid && !mem_we &&
                          (((state == ST_REQ) && mem_ready) || (state == ST_WAIT_R));

    // Store byte enables and lane-replicated store data
    always_comb begin
        case (f3_size(req_funct3))
            SZ_BYTE: begin
                st_strb  = 4'b0001 << req_addr[1:0];
                st_lanes = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_strb  = req_addr[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{req_wdata[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_lanes = req_wdata;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) state_nxt = req_misaligned ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                if (mem_ready) begin
                    if (mem_we || mem_rvalid) state_nxt = ST_DONE;
                    else                      state_nxt = ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                if (mem_rvalid) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Request capture: bus-facing fields stay frozen until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
            funct3_q  <= 3'd0;
            addr_lo_q <= 2'd0;
        end else if (accept) begin
            mem_we    <= req_we;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= st_lanes;
            mem_wstrb <= req_we ? st_strb : 4'b0000;
            funct3_q  <= req_funct3;
            addr_lo_q <= req_addr[1:0];
        end
    end

    lsu_load_align u_load_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .result  (load_result)
    );

    // Load result register, only touched when a load completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            ReadData <= 32'd0;
        else if (load_capture) ReadData <= load_result;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic fault_q;

    // Fault flag is high only in the DONE cycle that follows a trapped accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= accept && req_misaligned;
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table of load/store vectors plus hand-written
// reset and idle-bus sequences for load_store_unit.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        done;
    logic [31:0] ReadData;
    logic        fault;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_rvalid = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .done       (done),
        .ReadData   (ReadData),
        .fault      (fault),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdy_dly;
        int          rv_dly;
        logic        exp_valid;
        int          exp_lat;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_strb;
        logic [31:0] exp_rd;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One access with a small bus responder; everything observed is returned.
    task automatic run_access(input vec_t v, output int lat, output logic saw_valid,
                              output logic [31:0] m_addr, output logic [31:0] m_wdata,
                              output logic [3:0] m_strb, output logic m_we,
                              output logic f_done, output logic stable_ok,
                              output int pulses, output logic ready_ok);
        int   vcnt;
        int   wcnt;
        logic hs;
        logic rv_sent;
        lat = -1; saw_valid = 0; m_addr = 0; m_wdata = 0; m_strb = 0; m_we = 0;
        f_done = 0; stable_ok = 1; pulses = 0; ready_ok = 1;
        vcnt = 0; wcnt = 0; hs = 0; rv_sent = 0;
        @(negedge clk);
        if (req_ready !== 1'b1) ready_ok = 0;
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (lat < 0 && req_ready !== 1'b0) ready_ok = 0;
            if (done === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    f_done = fault;
                end
            end
            if (mem_valid === 1'b1) begin
                if (!saw_valid) begin
                    saw_valid = 1;
                    m_addr = mem_addr; m_wdata = mem_wdata; m_strb = mem_wstrb; m_we = mem_we;
                end else if (mem_addr !== m_addr || mem_wdata !== m_wdata ||
                             mem_wstrb !== m_strb || mem_we !== m_we) begin
                    stable_ok = 0;
                end
                vcnt++;
                if (vcnt > v.rdy_dly) begin
                    mem_ready = 1'b1;
                    hs = 1;
                    if (!v.we && v.rv_dly == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = v.rdata;
                        rv_sent    = 1;
                    end
                end
            end else if (hs && !v.we && !rv_sent) begin
                wcnt++;
                if (wcnt >= v.rv_dly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = v.rdata;
                    rv_sent    = 1;
                end
            end
            if (lat > 0 && k >= lat + 2) break;
        end
    endtask

    initial begin
        int          lat;
        int          pulses;
        logic        saw_valid, m_we, f_done, stable_ok, ready_ok;
        logic [31:0] m_addr, m_wdata;
        logic [3:0]  m_strb;
        int          dcount;

        //          we    f3      addr          wdata         rdata         rdy rv vld lat exp_addr      exp_wdata     strb     exp_rd        flt
        vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 0, 1'b1, 2, 32'h0000_0100, 32'h0,        4'b0000, 32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8011_2233, 0, 0, 1'b1, 2, 32'h0000_0100, 32'h0,        4'b0000, 32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h8011_2233, 0, 0, 1'b1, 2, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_0080, 1'b0};
        vecs[3]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0,        0, 0, 1'b1, 2, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100, 32'h0000_0080, 1'b0};
        vecs[4]  = '{1'b1, 3'b000, 32'h0000_0301, 32'h1234_56EF, 32'h0,        0, 0, 1'b1, 2, 32'h0000_0300, 32'hEFEF_EFEF, 4'b0010, 32'h0000_0080, 1'b0};
        vecs[5]  = '{1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,        5, 0, 1'b1, 7, 32'h0000_0400, 32'hCAFE_F00D, 4'b1111, 32'h0000_0080, 1'b0};
        vecs[6]  = '{1'b0, 3'b001, 32'h0000_0402, 32'h0,        32'h8001_7FFF, 2, 3, 1'b1, 7, 32'h0000_0400, 32'h0,        4'b0000, 32'hFFFF_8001, 1'b0};
        vecs[7]  = '{1'b0, 3'b101, 32'h0000_0402, 32'h0,        32'h8001_7FFF, 0, 1, 1'b1, 3, 32'h0000_0400, 32'h0,        4'b0000, 32'h0000_8001, 1'b0};
        vecs[8]  = '{1'b0, 3'b001, 32'h0000_0400, 32'h0,        32'h8001_7FFF, 0, 0, 1'b1, 2, 32'h0000_0400, 32'h0,        4'b0000, 32'h0000_7FFF, 1'b0};
        vecs[9]  = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h1122_3344, 0, 0, 1'b1, 2, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_0033, 1'b0};
        vecs[10] = '{1'b0, 3'b011, 32'h0000_0500, 32'h0,        32'h8765_4321, 0, 0, 1'b1, 2, 32'h0000_0500, 32'h0,        4'b0000, 32'h8765_4321, 1'b0};
        vecs[11] = '{1'b1, 3'b111, 32'h0000_0504, 32'h0102_0304, 32'h0,        0, 0, 1'b1, 2, 32'h0000_0504, 32'h0102_0304, 4'b1111, 32'h8765_4321, 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[12] = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0BAD_F00D, 0, 0, 1'b0, 1, 32'h0,         32'h0,        4'b0000, 32'h8765_4321, 1'b1};
        vecs[13] = '{1'b0, 3'b001, 32'h0000_0203, 32'h0,        32'hAAAA_5555, 0, 0, 1'b0, 1, 32'h0,         32'h0,        4'b0000, 32'h8765_4321, 1'b1};
`else
        vecs[12] = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0BAD_F00D, 0, 0, 1'b1, 2, 32'h0000_0100, 32'h0,        4'b0000, 32'h0BAD_F00D, 1'b0};
        vecs[13] = '{1'b0, 3'b001, 32'h0000_0203, 32'h0,        32'hAAAA_5555, 0, 0, 1'b1, 2, 32'h0000_0200, 32'h0,        4'b0000, 32'hFFFF_AAAA, 1'b0};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst req_ready", {31'd0, req_ready}, 32'd1);
        check("rst done",      {31'd0, done},      32'd0);
        check("rst fault",     {31'd0, fault},     32'd0);
        check("rst mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst mem_we",    {31'd0, mem_we},    32'd0);
        check("rst mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst mem_addr",  mem_addr,           32'd0);
        check("rst mem_wdata", mem_wdata,          32'd0);
        check("rst ReadData",  ReadData,           32'd0);
        rst_n = 1'b1;

        // Table of directed accesses
        for (int i = 0; i < 14; i++) begin
            run_access(vecs[i], lat, saw_valid, m_addr, m_wdata, m_strb, m_we,
                       f_done, stable_ok, pulses, ready_ok);
            check($sformatf("v%0d latency", i),   lat,                 vecs[i].exp_lat);
            check($sformatf("v%0d mem_valid", i), {31'd0, saw_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d mem_addr", i),  m_addr,          vecs[i].exp_addr);
                check($sformatf("v%0d mem_wstrb", i), {28'd0, m_strb}, {28'd0, vecs[i].exp_strb});
                check($sformatf("v%0d mem_wdata", i), m_wdata,         vecs[i].exp_wdata);
                check($sformatf("v%0d mem_we", i),    {31'd0, m_we},   {31'd0, vecs[i].we});
                check($sformatf("v%0d stable", i),    {31'd0, stable_ok}, 32'd1);
            end
            check($sformatf("v%0d ReadData", i),  ReadData,            vecs[i].exp_rd);
            check($sformatf("v%0d fault", i),     {31'd0, f_done},     {31'd0, vecs[i].exp_fault});
            check($sformatf("v%0d done pulses", i), pulses,            1);
            check($sformatf("v%0d req_ready", i), {31'd0, ready_ok},   32'd1);
        end

        // Read-data valid while idle is ignored
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("idle rvalid done",     {31'd0, done}, 32'd0);
        @(negedge clk);
        check("idle rvalid ReadData", ReadData, vecs[13].exp_rd);

        // Reset while the request is on the bus drops mem_valid at once
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h700;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        mem_ready = 1'b0;
        check("pre-reset mem_valid", {31'd0, mem_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async reset mem_valid", {31'd0, mem_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while waiting for read data: no done pulse, result cleared
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h800;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("wait_r mem_valid", {31'd0, mem_valid}, 32'd0);
        check("wait_r req_ready", {31'd0, req_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1 check("wait_r reset ReadData", ReadData, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h2468_ACE0;
        dcount = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (done === 1'b1) dcount++;
        end
        check("abandoned done pulses", dcount, 0);
        check("abandoned ReadData",    ReadData, 32'd0);

        // Fresh load after the abandoned access
        run_access('{1'b0, 3'b010, 32'h0000_0900, 32'h0, 32'h1357_9BDF, 0, 0, 1'b1, 2,
                     32'h0000_0900, 32'h0, 4'b0000, 32'h1357_9BDF, 1'b0},
                   lat, saw_valid, m_addr, m_wdata, m_strb, m_we, f_done, stable_ok, pulses, ready_ok);
        check("fresh latency",  lat,      2);
        check("fresh mem_addr", m_addr,   32'h0000_0900);
        check("fresh ReadData", ReadData, 32'h1357_9BDF);
        check("fresh pulses",   pulses,   1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
